// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU / multiply-divide unit.
// Contents: op-code constants, FSM state encoding, and op-class helpers
// used by the top level to steer requests to the single-cycle path or
// the iterative multiply/divide datapath.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
    localparam logic [3:0] OP_NOR   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    // True for ops that run on the iterative datapath.
    function automatic logic is_multicycle(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // True for the two divide ops.
    function automatic logic is_divide(input logic [3:0] op);
        case (op)
            OP_DIV, OP_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load magnitudes and begin WIDTH iterations
//   is_div        select divide (1) or multiply (0), sampled with start
//   mag_a, mag_b  unsigned multiplier/multiplicand or dividend/divisor
//   done          one-cycle pulse after the last iteration
//   raw           2*WIDTH result: product, or {remainder, quotient}
// The same 2*WIDTH register serves both ops: its low half starts with
// mag_a and is shifted out one bit per cycle while the upper half builds
// the partial product or partial remainder.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   raw
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0]   count_r;
    logic               run_r;
    logic               div_r;
    logic               done_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] work_r;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH-1:0]   sub_s;
    logic               fits_s;
    logic [2*WIDTH-1:0] step_s;

    // One iteration: shift-add for multiply, trial subtract for divide.
    always_comb begin
        add_s  = {1'b0, work_r[2*WIDTH-1:WIDTH]}
               + (work_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shl_s  = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
        sub_s  = shl_s[WIDTH-1:0] - b_r;
        fits_s = (shl_s >= {1'b0, b_r});
        if (div_r) begin
            if (fits_s) begin
                step_s = {sub_s, work_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {shl_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {add_s, work_r[WIDTH-1:1]};
        end
    end

    // Load, iterate WIDTH times, then hold the result until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
            run_r   <= 1'b0;
            div_r   <= 1'b0;
            done_r  <= 1'b0;
            b_r     <= {WIDTH{1'b0}};
            work_r  <= {(2*WIDTH){1'b0}};
        end else if (start) begin
            count_r <= CNT_LAST;
            run_r   <= 1'b1;
            div_r   <= is_div;
            done_r  <= 1'b0;
            b_r     <= mag_b;
            work_r  <= {{WIDTH{1'b0}}, mag_a};
        end else if (run_r) begin
            work_r <= step_s;
            if (count_r == CNT_ZERO) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                count_r <= count_r - CNT_ONE;
                done_r  <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign raw  = work_r;

endmodule

// File: rtl/seq_alu_mdu.sv
// Execute-stage ALU with one registered cycle of latency for logic,
// shift and arithmetic ops, plus an iterative multiply/divide unit that
// owns the architectural HI/LO registers.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   request handshake (in_ready only in IDLE)
//   op, operand_a,
//   operand_b, shamt     request fields, sampled on accept
//   out_valid            one-cycle pulse qualifying result/zero/div_by_zero
//   result, zero         registered result and (operand_a == operand_b)
//   div_by_zero          divide with zero divisor, valid with out_valid
//   busy                 multi-cycle op in progress
module seq_alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               div_by_zero,
    output logic               busy
);

    state_t state_r, state_next_s;

    logic             ready_r, busy_r, out_valid_r, zero_r, dbz_r;
    logic [WIDTH-1:0] result_r, hi_r, lo_r, a_r;
    logic             pend_div_r, pend_bz_r, pend_zero_r, neg_res_r, neg_rem_r;

    logic               accept_s, multi_s, div_op_s, signed_op_s;
    logic               a_neg_s, b_neg_s, mdu_start_s, mdu_done_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, alu_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, fix_hi_s, fix_lo_s;
    logic [2*WIDTH-1:0] raw_s, prod_fix_s;

    assign accept_s    = in_valid && ready_r;
    assign multi_s     = is_multicycle(op);
    assign div_op_s    = is_divide(op);
    assign signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg_s     = signed_op_s && operand_a[WIDTH-1];
    assign b_neg_s     = signed_op_s && operand_b[WIDTH-1];
    // Two's-complement negation of the minimum value yields 2^(W-1),
    // which is the correct unsigned magnitude.
    assign mag_a_s     = a_neg_s ? -operand_a : operand_a;
    assign mag_b_s     = b_neg_s ? -operand_b : operand_b;
    assign mdu_start_s = accept_s && multi_s;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start_s),
        .is_div (div_op_s),
        .mag_a  (mag_a_s),
        .mag_b  (mag_b_s),
        .done   (mdu_done_s),
        .raw    (raw_s)
    );

    // Single-cycle op result.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (op)
            OP_AND:  alu_s = operand_a & operand_b;
            OP_OR:   alu_s = operand_a | operand_b;
            OP_ADD:  alu_s = operand_a + operand_b;
            OP_SLL:  alu_s = operand_b << shamt;
            OP_SRL:  alu_s = operand_b >> shamt;
            OP_SRA:  alu_s = $unsigned($signed(operand_b) >>> shamt);
            OP_SUB:  alu_s = operand_a - operand_b;
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_XOR:  alu_s = operand_a ^ operand_b;
            OP_MFHI: alu_s = hi_r;
            OP_MFLO: alu_s = lo_r;
            OP_NOR:  alu_s = ~(operand_a | operand_b);
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Sign correction of the unsigned datapath result and HI/LO selection.
    always_comb begin
        if (neg_res_r) begin
            prod_fix_s = -raw_s;
            quo_fix_s  = -raw_s[WIDTH-1:0];
        end else begin
            prod_fix_s = raw_s;
            quo_fix_s  = raw_s[WIDTH-1:0];
        end
        // Remainder follows the dividend's sign.
        if (neg_rem_r) begin
            rem_fix_s = -raw_s[2*WIDTH-1:WIDTH];
        end else begin
            rem_fix_s = raw_s[2*WIDTH-1:WIDTH];
        end
        if (pend_bz_r) begin
            fix_hi_s = a_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else if (pend_div_r) begin
            fix_hi_s = rem_fix_s;
            fix_lo_s = quo_fix_s;
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && multi_s) begin
                    state_next_s = div_op_s ? S_DIV : S_MUL;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (mdu_done_s) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_FIX:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Handshake flags, output registers, pending request info and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            dbz_r       <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            pend_div_r  <= 1'b0;
            pend_bz_r   <= 1'b0;
            pend_zero_r <= 1'b0;
            neg_res_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
        end else begin
            ready_r     <= (state_next_s == S_IDLE);
            busy_r      <= (state_next_s != S_IDLE);
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
            if (accept_s) begin
                if (multi_s) begin
                    a_r         <= operand_a;
                    pend_div_r  <= div_op_s;
                    pend_bz_r   <= div_op_s && (operand_b == {WIDTH{1'b0}});
                    pend_zero_r <= (operand_a == operand_b);
                    neg_res_r   <= a_neg_s ^ b_neg_s;
                    neg_rem_r   <= a_neg_s;
                end else begin
                    out_valid_r <= 1'b1;
                    result_r    <= alu_s;
                    zero_r      <= (operand_a == operand_b);
                end
            end else if (state_r == S_FIX) begin
                out_valid_r <= 1'b1;
                result_r    <= fix_lo_s;
                zero_r      <= pend_zero_r;
                dbz_r       <= pend_bz_r;
                hi_r        <= fix_hi_s;
                lo_r        <= fix_lo_s;
            end
        end
    end

    assign in_ready    = ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign zero        = zero_r;
    assign div_by_zero = dbz_r;

endmodule
